// File: rtl/lsu_align.sv
// lsu_align: load/store alignment unit between MEM-stage control and a
// word-wide data memory (combinational read, full-word write).
// Handles one byte-addressed RV32 access at a time: lane steering with
// sign/zero extension for loads, read-modify-write for sub-word stores,
// and splitting of word-crossing accesses into two word accesses.
//
// Ports
//   clk, reset         : clock, async active-high reset
//   req_valid/ready    : request handshake (ready = unit idle)
//   req_we, req_funct3 : store flag, RV32 size/sign code
//   req_addr, req_wdata: byte address ({word index, offset}), store data
//   resp_valid/data/err: one-cycle completion pulse, load result, illegal op
//   mem_a/re/we/wd/rd  : word index, read strobe, write enable, write/read data
module lsu_align #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS+1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_data,
  output logic                  resp_err,
  output logic [DM_ADDRESS-1:0] mem_a,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wd,
  input  logic [DATA_W-1:0]     mem_rd
);
  localparam int LANES = 2 * DATA_W / 8;  // byte lanes across the two-word window

  typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, RESP} state_t;

  function automatic logic [2:0] size_of(input logic [1:0] sz);
    case (sz)
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

  function automatic logic legal(input logic we, input logic [2:0] f3);
    if (we) legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    else    legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
  endfunction

  state_t                  state, state_nx;
  logic                    we_q, err_q;
  logic [2:0]              f3_q;
  logic [1:0]              off_q;
  logic [DM_ADDRESS-1:0]   idx_q, idx_nx;
  logic [DATA_W-1:0]       wdata_q, buf0, buf1;
  logic [2:0]              size_q;
  logic                    cross_q;
  logic [2*DATA_W-1:0]     pair, merged;
  logic [DATA_W-1:0]       lo, load_val;
  logic                    req_legal, req_sw_aligned;

  assign req_legal      = legal(req_we, req_funct3);
  assign req_sw_aligned = req_we && (req_funct3 == 3'b010) && (req_addr[1:0] == 2'b00);
  assign size_q         = size_of(f3_q[1:0]);
  assign cross_q        = ({1'b0, off_q} + size_q) > 3'd4;
  assign idx_nx         = idx_q + DM_ADDRESS'(1);  // wraps at the top of memory
  assign pair           = {buf1, buf0};

  // Store merge: lane k takes wdata byte (k - offset) when inside the access.
  // rel underflows to >= 13 for lanes below the offset, so they never hit.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [3:0] rel;
    logic       hit;
    assign rel = 4'(k) - {2'b00, off_q};
    assign hit = rel < {1'b0, size_q};
    assign merged[8*k +: 8] = hit ? wdata_q[{rel[1:0], 3'b000} +: 8] : pair[8*k +: 8];
  end

  // Load extraction from the two-word window.
  always_comb begin
    lo = DATA_W'(pair >> {off_q, 3'b000});
    case (f3_q)
      3'b000:  load_val = {{24{lo[7]}},  lo[7:0]};
      3'b001:  load_val = {{16{lo[15]}}, lo[15:0]};
      3'b100:  load_val = {24'd0, lo[7:0]};
      3'b101:  load_val = {16'd0, lo[15:0]};
      default: load_val = lo;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      idx_q   <= '0;
      wdata_q <= '0;
      buf0    <= '0;
      buf1    <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        err_q   <= !req_legal;
        f3_q    <= req_funct3;
        off_q   <= req_addr[1:0];
        idx_q   <= req_addr[DM_ADDRESS+1:2];
        wdata_q <= req_wdata;
      end
      if (state == RD0) buf0 <= mem_rd;
      if (state == RD1) buf1 <= mem_rd;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req_valid) begin
        if (!req_legal)          state_nx = RESP;
        else if (req_sw_aligned) state_nx = WR0;  // full word: no read needed
        else                     state_nx = RD0;
      end
      RD0:     state_nx = cross_q ? RD1 : (we_q ? WR0 : RESP);
      RD1:     state_nx = we_q ? WR0 : RESP;
      WR0:     state_nx = cross_q ? WR1 : RESP;
      WR1:     state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE) && !reset;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_data  = '0;
    mem_a      = '0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_wd     = '0;
    case (state)
      RD0: begin mem_a = idx_q;  mem_re = 1'b1; end
      RD1: begin mem_a = idx_nx; mem_re = 1'b1; end
      WR0: begin mem_a = idx_q;  mem_we = 1'b1; mem_wd = merged[DATA_W-1:0]; end
      WR1: begin mem_a = idx_nx; mem_we = 1'b1; mem_wd = merged[2*DATA_W-1:DATA_W]; end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!err_q && !we_q) resp_data = load_val;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_lsu_align.sv
// Bench for lsu_align: word memory model, negedge monitor that records each
// transaction, and expected-result queue popped against observed responses.
module tb_lsu_align;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [10:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_data;
  logic [8:0]  mem_a;
  logic        mem_re, mem_we;
  logic [31:0] mem_wd, mem_rd;

  always #5 clk = ~clk;

  lsu_align #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .mem_a(mem_a), .mem_re(mem_re), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // memory model
  logic [31:0] mem [0:511];
  logic        pl_en = 1'b0;
  logic [8:0]  pl_a = '0;
  logic [31:0] pl_d = '0;
  assign mem_rd = mem[mem_a];
  always @(posedge clk) begin
    if (mem_we)     mem[mem_a] <= mem_wd;
    else if (pl_en) mem[pl_a]  <= pl_d;
  end

  typedef struct {
    logic [31:0] data; logic err; int lat; int re_n; int we_n;
    logic [8:0] ra0, ra1, wa0, wa1; logic bus_busy; int stall;
  } obs_t;
  typedef struct { logic [31:0] data; logic err; int lat; int re_n; int we_n; } exp_t;

  obs_t obs_q[$];
  exp_t exp_q[$];
  int   checks = 0, failures = 0;
  int   both_viol = 0;

  // monitor: latency counted in negedges after the accept edge
  initial begin
    int cyc = 0, re_n = 0, we_n = 0, stall = 0, acc_stall = 0;
    logic [8:0] ra0 = '0, ra1 = '0, wa0 = '0, wa1 = '0;
    obs_t o;
    forever begin
      @(negedge clk);
      if (reset) stall = 0;
      else if (req_valid && req_ready) begin
        cyc = 0; re_n = 0; we_n = 0; ra0 = '0; ra1 = '0; wa0 = '0; wa1 = '0;
        acc_stall = stall; stall = 0;
      end else begin
        if (req_valid) stall++;
        cyc++;
        if (mem_re) begin if (re_n == 0) ra0 = mem_a; else if (re_n == 1) ra1 = mem_a; re_n++; end
        if (mem_we) begin if (we_n == 0) wa0 = mem_a; else if (we_n == 1) wa1 = mem_a; we_n++; end
        if (mem_re && mem_we) both_viol++;
        if (resp_valid) begin
          o.data = resp_data; o.err = resp_err; o.lat = cyc; o.re_n = re_n; o.we_n = we_n;
          o.ra0 = ra0; o.ra1 = ra1; o.wa0 = wa0; o.wa1 = wa1; o.stall = acc_stall;
          o.bus_busy = (mem_a != 9'd0) || (mem_wd != 32'd0) || mem_re || mem_we;
          obs_q.push_back(o);
        end
      end
    end
  end

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    @(posedge clk); #1; pl_en = 1'b1; pl_a = a; pl_d = d;
    @(posedge clk); #1; pl_en = 1'b0;
  endtask

  // drive one request, queue its expectation, wait (bounded) for the response
  task automatic xact(input logic we, input logic [2:0] f3, input logic [10:0] addr,
                      input logic [31:0] wd, input exp_t e,
                      output exp_t eo, output obs_t o, output bit ok);
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    // scramble inputs after accept: captured values must hold
    req_valid = 1'b0; req_we = 1'($urandom()); req_funct3 = 3'($urandom());
    req_addr = 11'($urandom()); req_wdata = $urandom();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (obs_q.size() != 0) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    eo = exp_q.pop_front();
    o = '{default: 0};
    if (ok) o = obs_q.pop_front();
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0;
    #2;
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_re, mem_we} !== 5'd0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=00000", {req_ready, resp_valid, resp_err, mem_re, mem_we});
    end
    checks++;
    if ({resp_data, mem_wd, mem_a} !== 73'd0) begin
      failures++; $display("FAIL reset_bus got=%h/%h/%h exp=0", resp_data, mem_wd, mem_a);
    end
    preload(9'd0, 32'h44332211);
    preload(9'd1, 32'h88776655);
    preload(9'd2, 32'h00000000);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%b exp=1", req_ready); end
  endtask

  task automatic test_loads;
    logic [2:0]  f3s [7] = '{3'b010, 3'b000, 3'b000, 3'b100, 3'b101, 3'b001, 3'b010};
    logic [10:0] ads [7] = '{11'd0, 11'd3, 11'd7, 11'd7, 11'd6, 11'd3, 11'd2};
    logic [31:0] dts [7] = '{32'h44332211, 32'h00000044, 32'hFFFFFF88, 32'h00000088,
                             32'h00008877, 32'h00005544, 32'h66554433};
    int          lts [7] = '{2, 2, 2, 2, 2, 3, 3};
    exp_t e, eo; obs_t o; bit ok;
    for (int i = 0; i < 7; i++) begin
      logic [10:0] a;
      logic [8:0]  idx;
      a = ads[i]; idx = a[10:2];
      e = '{dts[i], 1'b0, lts[i], lts[i] - 1, 0};
      xact(1'b0, f3s[i], a, 32'hA5A5A5A5, e, eo, o, ok);
      if (!ok) begin checks++; failures++; $display("FAIL load%0d timeout", i); continue; end
      checks++;
      if (o.data !== eo.data) begin failures++; $display("FAIL load%0d data got=%h exp=%h", i, o.data, eo.data); end
      checks++;
      if (o.err !== eo.err) begin failures++; $display("FAIL load%0d err got=%b exp=%b", i, o.err, eo.err); end
      checks++;
      if (o.lat !== eo.lat) begin failures++; $display("FAIL load%0d latency got=%0d exp=%0d", i, o.lat, eo.lat); end
      checks++;
      if (o.re_n !== eo.re_n || o.we_n !== eo.we_n) begin
        failures++; $display("FAIL load%0d strobes got=re%0d/we%0d exp=re%0d/we%0d", i, o.re_n, o.we_n, eo.re_n, eo.we_n);
      end
      checks++;
      if (o.ra0 !== idx) begin failures++; $display("FAIL load%0d addr0 got=%0d exp=%0d", i, o.ra0, idx); end
      if (eo.lat == 3) begin
        checks++;
        if (o.ra1 !== idx + 9'd1) begin failures++; $display("FAIL load%0d addr1 got=%0d exp=%0d", i, o.ra1, idx + 9'd1); end
      end
      checks++;
      if (o.bus_busy !== 1'b0) begin failures++; $display("FAIL load%0d resp_bus got=busy exp=idle", i); end
    end
  endtask

  task automatic test_stores;
    exp_t eo; obs_t o; bit ok;
    // SB into lane 1 of word 0
    xact(1'b1, 3'b000, 11'd1, 32'hDEADBEEF, '{32'd0, 1'b0, 3, 1, 1}, eo, o, ok);
    if (!ok) begin checks++; failures++; $display("FAIL sb timeout"); end
    else begin
      checks++;
      if (o.lat !== eo.lat || o.we_n !== eo.we_n || o.re_n !== eo.re_n) begin
        failures++; $display("FAIL sb timing got=lat%0d/we%0d/re%0d exp=lat%0d/we%0d/re%0d", o.lat, o.we_n, o.re_n, eo.lat, eo.we_n, eo.re_n);
      end
      checks++;
      if (mem[0] !== 32'h4433EF11) begin failures++; $display("FAIL sb mem0 got=%h exp=4433ef11", mem[0]); end
    end
    // crossing SW at offset 2 of word 1
    xact(1'b1, 3'b010, 11'd6, 32'hCAFEF00D, '{32'd0, 1'b0, 5, 2, 2}, eo, o, ok);
    if (!ok) begin checks++; failures++; $display("FAIL sw_cross timeout"); end
    else begin
      checks++;
      if (o.data !== eo.data || o.lat !== eo.lat) begin
        failures++; $display("FAIL sw_cross resp got=%h/lat%0d exp=%h/lat%0d", o.data, o.lat, eo.data, eo.lat);
      end
      checks++;
      if (o.we_n !== eo.we_n || o.wa0 !== 9'd1 || o.wa1 !== 9'd2) begin
        failures++; $display("FAIL sw_cross writes got=%0d@%0d,%0d exp=2@1,2", o.we_n, o.wa0, o.wa1);
      end
      checks++;
      if (mem[1] !== 32'hF00D6655 || mem[2] !== 32'h0000CAFE) begin
        failures++; $display("FAIL sw_cross mem got=%h,%h exp=f00d6655,0000cafe", mem[1], mem[2]);
      end
    end
    // crossing SH at offset 3 of word 0
    xact(1'b1, 3'b001, 11'd3, 32'h1234BEEF, '{32'd0, 1'b0, 5, 2, 2}, eo, o, ok);
    if (!ok) begin checks++; failures++; $display("FAIL sh_cross timeout"); end
    else begin
      checks++;
      if (o.lat !== eo.lat) begin failures++; $display("FAIL sh_cross latency got=%0d exp=%0d", o.lat, eo.lat); end
      checks++;
      if (mem[0] !== 32'hEF33EF11 || mem[1] !== 32'hF00D66BE) begin
        failures++; $display("FAIL sh_cross mem got=%h,%h exp=ef33ef11,f00d66be", mem[0], mem[1]);
      end
    end
    // aligned SW: direct write, no read
    xact(1'b1, 3'b010, 11'd8, 32'h12345678, '{32'd0, 1'b0, 2, 0, 1}, eo, o, ok);
    if (!ok) begin checks++; failures++; $display("FAIL sw_aligned timeout"); end
    else begin
      checks++;
      if (o.lat !== eo.lat || o.re_n !== eo.re_n || o.we_n !== eo.we_n) begin
        failures++; $display("FAIL sw_aligned timing got=lat%0d/re%0d/we%0d exp=lat%0d/re%0d/we%0d", o.lat, o.re_n, o.we_n, eo.lat, eo.re_n, eo.we_n);
      end
      checks++;
      if (mem[2] !== 32'h12345678) begin failures++; $display("FAIL sw_aligned mem2 got=%h exp=12345678", mem[2]); end
    end
  endtask

  task automatic test_illegal;
    logic        wes [3] = '{1'b0, 1'b0, 1'b1};
    logic [2:0]  f3s [3] = '{3'b011, 3'b111, 3'b100};
    exp_t eo; obs_t o; bit ok;
    logic [31:0] m0;
    m0 = mem[0];
    for (int i = 0; i < 3; i++) begin
      xact(wes[i], f3s[i], 11'd0, 32'hFFFFFFFF, '{32'd0, 1'b1, 1, 0, 0}, eo, o, ok);
      if (!ok) begin checks++; failures++; $display("FAIL illegal%0d timeout", i); continue; end
      checks++;
      if (o.err !== eo.err || o.data !== eo.data) begin
        failures++; $display("FAIL illegal%0d resp got=err%b/%h exp=err%b/%h", i, o.err, o.data, eo.err, eo.data);
      end
      checks++;
      if (o.lat !== eo.lat || o.re_n !== 0 || o.we_n !== 0) begin
        failures++; $display("FAIL illegal%0d access got=lat%0d/re%0d/we%0d exp=lat1/re0/we0", i, o.lat, o.re_n, o.we_n);
      end
    end
    checks++;
    if (mem[0] !== m0) begin failures++; $display("FAIL illegal_mem0 got=%h exp=%h", mem[0], m0); end
  endtask

  task automatic test_wrap;
    exp_t eo; obs_t o; bit ok;
    preload(9'd511, 32'hA1B2C3D4);
    preload(9'd0, 32'h44332211);
    xact(1'b0, 3'b010, 11'h7FE, 32'd0, '{32'h2211A1B2, 1'b0, 3, 2, 0}, eo, o, ok);
    if (!ok) begin checks++; failures++; $display("FAIL wrap timeout"); end
    else begin
      checks++;
      if (o.data !== eo.data) begin failures++; $display("FAIL wrap data got=%h exp=%h", o.data, eo.data); end
      checks++;
      if (o.ra0 !== 9'd511 || o.ra1 !== 9'd0 || o.lat !== eo.lat) begin
        failures++; $display("FAIL wrap addr got=%0d,%0d lat%0d exp=511,0 lat3", o.ra0, o.ra1, o.lat);
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t e1, e2; obs_t o1, o2; bit ok;
    preload(9'd0, 32'h44332211);
    preload(9'd1, 32'h88776655);
    exp_q.push_back('{32'h00000022, 1'b0, 2, 1, 0});
    exp_q.push_back('{32'hFFFFFF88, 1'b0, 2, 1, 0});
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b100; req_addr = 11'd1;
    @(posedge clk); #1;
    // second request held while busy; must not disturb the first
    req_funct3 = 3'b000; req_addr = 11'd7;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1; req_valid = 1'b0;
    for (int i = 0; i < 20 && obs_q.size() < 2; i++) begin @(negedge clk); #1; end
    e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
    if (!ok || obs_q.size() < 2) begin
      checks++; failures++; $display("FAIL b2b timeout got=%0d responses exp=2", obs_q.size());
      obs_q.delete();
    end else begin
      o1 = obs_q.pop_front(); o2 = obs_q.pop_front();
      checks++;
      if (o1.data !== e1.data || o1.lat !== e1.lat) begin
        failures++; $display("FAIL b2b first got=%h/lat%0d exp=%h/lat%0d", o1.data, o1.lat, e1.data, e1.lat);
      end
      checks++;
      if (o2.data !== e2.data || o2.lat !== e2.lat) begin
        failures++; $display("FAIL b2b second got=%h/lat%0d exp=%h/lat%0d", o2.data, o2.lat, e2.data, e2.lat);
      end
      checks++;
      if (o2.stall !== 2) begin failures++; $display("FAIL b2b stall_cycles got=%0d exp=2", o2.stall); end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    preload(9'd4, 32'h11111111);
    preload(9'd5, 32'h22222222);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 11'd17; req_wdata = 32'hAABBCCDD;
    @(posedge clk); #1; req_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_we && mem_a == 9'd5) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL rstmid no_wr1 got=none exp=write@5"); end
    reset = 1'b1;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_re, mem_we} !== 5'd0 || {resp_data, mem_wd, mem_a} !== 73'd0) begin
      failures++; $display("FAIL rstmid outputs got=%b %h %h %h exp=0", {req_ready, resp_valid, resp_err, mem_re, mem_we}, resp_data, mem_wd, mem_a);
    end
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (mem[4] !== 32'hBBCCDD11 || mem[5] !== 32'h22222222) begin
      failures++; $display("FAIL rstmid mem got=%h,%h exp=bbccdd11,22222222", mem[4], mem[5]);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || obs_q.size() != 0) begin
      failures++; $display("FAIL rstmid recover got=ready%b/resp%0d exp=ready1/resp0", req_ready, obs_q.size());
    end
  endtask

  task automatic test_invariants;
    checks++;
    if (both_viol !== 0) begin failures++; $display("FAIL re_we_overlap got=%0d exp=0", both_viol); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_illegal();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/lsu_align.md
# lsu_align

Load/store alignment unit between the MEM-stage pipeline control and the word-wide data memory, which has a combinational read and a full-word write. Accepts one byte-addressed RV32 load or store at a time. Performs lane steering with sign or zero extension. Implements sub-word stores as read-modify-write and splits word-crossing accesses into two word accesses. The pipeline stalls on `req_ready` low and consumes the `resp_*` outputs.

## Interface
- `DM_ADDRESS`, 9: memory word-index width.
- `DATA_W`, 32: data width. Only 32 is supported.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle; a request is accepted when `req_valid && req_ready` at an edge.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr` in `DM_ADDRESS+2`: byte address. Bits [1:0] are the byte offset, upper bits are the word index.
- `req_wdata` in 32: store data, least-significant bytes used.
- `resp_valid` out 1: one-cycle completion pulse, for loads and stores.
- `resp_data` out 32: load result. 0 for stores, errors, and whenever `resp_valid` is 0.
- `resp_err` out 1: illegal `req_funct3`, qualified by `resp_valid`.
- `mem_a` out `DM_ADDRESS`: word index to memory.
- `mem_re` out 1: read strobe.
- `mem_we` out 1: full-word write enable.
- `mem_wd` out 32: write word.
- `mem_rd` in 32: combinational read data for `mem_a`.

## Operation
- Size in bytes: B/BU = 1, H/HU = 2, W = 4.
- The access crosses into the next word when offset + size > 4 (H at offset 3, W at offset ≠ 0).
- Next word index = index + 1 mod 2^`DM_ADDRESS`, so index 511 wraps to 0.
- Byte order is little-endian: byte k of a word lives in bits [8k+7:8k].
- Illegal requests:
  - Loads with funct3 011, 110, 111.
  - Stores with funct3 other than 000, 001, 010.
  - An illegal request goes straight to RESP with `resp_err` = 1 and no memory access.
- State machine: IDLE, RD0, RD1, WR0, WR1, RESP.
  - IDLE: `req_ready` = 1. On accept, capture we/funct3/addr/wdata, then:
    - illegal → RESP
    - aligned SW → WR0
    - otherwise → RD0
  - RD0: `mem_a` = index, `mem_re` = 1, capture `mem_rd` into buf0. Then → RD1 if crossing, else WR0 (store) or RESP (load).
  - RD1: `mem_a` = index+1, `mem_re` = 1, capture buf1. Then → WR0 (store) or RESP (load).
  - WR0: `mem_a` = index, `mem_we` = 1, `mem_wd` = merged word 0. Then → WR1 if crossing, else RESP.
  - WR1: `mem_a` = index+1, `mem_we` = 1, `mem_wd` = merged word 1. Then → RESP.
  - RESP: `resp_valid` = 1, `req_ready` = 0. Then → IDLE.
- Load extraction:
  - Form {buf1, buf0}, shift right by 8·offset, keep `size` bytes.
  - Sign-extend for B/H; zero-extend for BU/HU/W.
  - buf1 is don't-care if the access does not cross.
- Store merge: overwrite only the `size` target byte lanes of buf0/buf1 with the low bytes of `req_wdata`, in ascending address order. An aligned SW writes `req_wdata` directly.
- Memory outputs are combinational from state and captured registers.
  - `mem_re` and `mem_we` are never both 1.
  - `mem_a`/`mem_wd` are 0 in IDLE and RESP.

## Timing
- Reset values (immediate, asynchronous):
  - State → IDLE.
  - `req_ready` = 0 while `reset` is high, 1 from the first cycle after release.
  - `resp_valid`, `resp_data`, `resp_err`, `mem_re`, `mem_we`, `mem_a`, `mem_wd` = 0.
- Latency is counted as cycles from the accept edge to the cycle in which `resp_valid` = 1:
  - aligned LW/LB/LH: 2
  - crossing load: 3
  - aligned SW: 2
  - non-crossing sub-word store: 3
  - crossing store: 5
  - illegal request: 1
- Throughput: the next request can be accepted on the edge that ends the IDLE cycle following RESP. No overlap.
- Request inputs are ignored while `req_ready` = 0. Captured values are not affected by input changes after accept.
- Reset mid-operation: aborts at once, with no further `mem_we`. If reset falls between WR0 and WR1, word 0 stays updated and word 1 unchanged; this is accepted behaviour.

## Test plan
- Preload mem[0] = 0x44332211, mem[1] = 0x88776655, mem[2] = 0. LW addr 0 → `resp_data` 0x44332211, 2 cycles after accept, `mem_we` never 1.
- LB addr 3 → 0x00000044. LB addr 7 → 0xFFFFFF88. LBU addr 7 → 0x00000088. LHU addr 6 → 0x00008877.
- LH addr 3 (crossing) → 0x00005544 at 3 cycles, `mem_a` sequence 0, 1. LW addr 2 → 0x66554433.
- SB addr 1, wdata 0xDEADBEEF → mem[0] = 0x4433EF11, latency 3, exactly one `mem_we` cycle.
- SW addr 6, wdata 0xCAFEF00D → mem[1] = 0xF00D6655, mem[2] = 0x0000CAFE, latency 5, `resp_data` 0.
- Edge cases:
  - Load funct3 011 → `resp_err` = 1, `resp_data` 0, no `mem_re`/`mem_we`, latency 1.
  - LW at byte addr 0x7FE → `mem_a` 511 then 0.
  - Reset asserted during WR1 of a crossing store → all outputs 0 in the same cycle, second word unchanged.
